// File: rtl/seqdet_search_ctrl.sv
// Search/lock sequencer for the 101001 pattern detector: flushes and arms the
// detector, counts hits inside a search window, then tracks lock until hits stop.
module seqdet_search_ctrl #(
    parameter int unsigned PAT_LEN    = 6,
    parameter int unsigned FLUSH_CYC  = 2,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned HIT_TARGET = 3,
    parameter int unsigned MAX_GAP    = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_pattern_found,
    output logic             o_det_resetn,
    output logic             o_busy,
    output logic             o_locked,
    output logic             o_timeout,
    output logic             o_lost,
    output logic [CNT_W-1:0] o_hit_count
);

    localparam int unsigned ARM_CYC = PAT_LEN - 1;
    localparam int unsigned MAX_A   = (WINDOW > MAX_GAP) ? WINDOW : MAX_GAP;
    localparam int unsigned MAX_B   = (FLUSH_CYC > PAT_LEN) ? FLUSH_CYC : PAT_LEN;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_ARM,
        ST_SEARCH,
        ST_TRACK
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [CNT_W-1:0] hit_sat;
    logic             target_hit;
    logic             timeout_d, lost_d;
    logic             det_resetn_q, busy_q, locked_q, timeout_q, lost_q;

    // One shared timer serves as flush length, arm wait, search window and track gap.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        hits_d     = hits_q;
        timeout_d  = 1'b0;
        lost_d     = 1'b0;
        hit_sat    = (hits_q == '1) ? hits_q : hits_q + CNT_W'(1);
        target_hit = ({1'b0, hits_q} + (CNT_W+1)'(1)) >= (CNT_W+1)'(HIT_TARGET);

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FLUSH;
                    tmr_d   = '0;
                    hits_d  = '0;
                end
            end
            ST_FLUSH: begin
                if (tmr_q == TW'(FLUSH_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = (ARM_CYC == 0) ? ST_SEARCH : ST_ARM;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_ARM: begin
                if (tmr_q == TW'(ARM_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_SEARCH;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_SEARCH: begin
                // A hit on the last window cycle is counted before the expiry check.
                if (i_pattern_found) begin
                    hits_d = hit_sat;
                end
                if (i_pattern_found && target_hit) begin
                    state_d = ST_TRACK;
                    tmr_d   = '0;
                end else if (tmr_q == TW'(WINDOW - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    tmr_d     = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_TRACK: begin
                if (i_pattern_found) begin
                    hits_d = hit_sat;
                    tmr_d  = '0;
                end else if (tmr_q == TW'(MAX_GAP - 1)) begin
                    lost_d  = 1'b1;
                    state_d = ST_FLUSH;
                    tmr_d   = '0;
                    hits_d  = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase

        // Abort overrides everything, including a same-cycle start, and never pulses status.
        if (i_abort) begin
            state_d   = ST_IDLE;
            tmr_d     = '0;
            hits_d    = hits_q;
            timeout_d = 1'b0;
            lost_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            hits_q       <= '0;
            det_resetn_q <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            hits_q       <= hits_d;
            det_resetn_q <= (state_d == ST_ARM) || (state_d == ST_SEARCH) || (state_d == ST_TRACK);
            busy_q       <= (state_d != ST_IDLE);
            locked_q     <= (state_d == ST_TRACK);
            timeout_q    <= timeout_d;
            lost_q       <= lost_d;
        end
    end

    assign o_det_resetn = det_resetn_q;
    assign o_busy       = busy_q;
    assign o_locked     = locked_q;
    assign o_timeout    = timeout_q;
    assign o_lost       = lost_q;
    assign o_hit_count  = hits_q;

endmodule

// File: tb/tb_seqdet_search_ctrl.sv
// Bench for seqdet_search_ctrl: directed scenarios plus randomized traffic,
// checked against a timestamp-based reference model.
module tb_seqdet_search_ctrl;

    localparam int PAT_LEN    = 6;
    localparam int FLUSH_CYC  = 2;
    localparam int WINDOW     = 64;
    localparam int HIT_TARGET = 3;
    localparam int MAX_GAP    = 16;
    localparam int CNT_W      = 8;
    localparam int HMAX       = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_start;
    logic             i_abort;
    logic             i_pattern_found;
    logic             o_det_resetn;
    logic             o_busy;
    logic             o_locked;
    logic             o_timeout;
    logic             o_lost;
    logic [CNT_W-1:0] o_hit_count;

    seqdet_search_ctrl #(
        .PAT_LEN   (PAT_LEN),
        .FLUSH_CYC (FLUSH_CYC),
        .WINDOW    (WINDOW),
        .HIT_TARGET(HIT_TARGET),
        .MAX_GAP   (MAX_GAP),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_pattern_found(i_pattern_found),
        .o_det_resetn   (o_det_resetn),
        .o_busy         (o_busy),
        .o_locked       (o_locked),
        .o_timeout      (o_timeout),
        .o_lost         (o_lost),
        .o_hit_count    (o_hit_count)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: arm time, last-hit time and a hit tally.
    bit m_active, m_locked, m_to, m_lost;
    int m_arm, m_last, m_hits;

    int n_to, n_lost, to_cyc, lost_cyc, last_hit_cyc, start_cyc, lows;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > HMAX) ? HMAX : v;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_locked = 1'b0;
        m_to     = 1'b0;
        m_lost   = 1'b0;
        m_arm    = 0;
        m_last   = 0;
        m_hits   = 0;
    endtask

    task automatic model_step(input bit st, input bit ab, input bit hit);
        int age;
        m_to   = 1'b0;
        m_lost = 1'b0;
        if (ab) begin
            m_active = 1'b0;
            m_locked = 1'b0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_arm    = cyc;
                m_hits   = 0;
            end
        end else begin
            age = cyc - m_arm;
            if (m_locked) begin
                if (hit) begin
                    m_hits = sat(m_hits + 1);
                    m_last = cyc;
                end else if (cyc - m_last == MAX_GAP) begin
                    m_lost   = 1'b1;
                    m_locked = 1'b0;
                    m_arm    = cyc;
                    m_hits   = 0;
                end
            end else if (age >= FLUSH_CYC + PAT_LEN) begin
                if (hit) begin
                    m_hits = sat(m_hits + 1);
                    if (m_hits >= HIT_TARGET) begin
                        m_locked = 1'b1;
                        m_last   = cyc;
                    end
                end
                if (!m_locked && age == FLUSH_CYC + PAT_LEN - 1 + WINDOW) begin
                    m_to     = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outs();
        chk("det_resetn", 32'(o_det_resetn), 32'(m_active && (cyc - m_arm >= FLUSH_CYC)));
        chk("busy",       32'(o_busy),       32'(m_active));
        chk("locked",     32'(o_locked),     32'(m_locked));
        chk("timeout",    32'(o_timeout),    32'(m_to));
        chk("lost",       32'(o_lost),       32'(m_lost));
        chk("hit_count",  32'(o_hit_count),  32'(m_hits));
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_det_resetn"}, 32'(o_det_resetn), 32'(0));
        chk({tag, "_busy"},       32'(o_busy),       32'(0));
        chk({tag, "_locked"},     32'(o_locked),     32'(0));
        chk({tag, "_timeout"},    32'(o_timeout),    32'(0));
        chk({tag, "_lost"},       32'(o_lost),       32'(0));
        chk({tag, "_hit_count"},  32'(o_hit_count),  32'(0));
    endtask

    // Called just after a falling edge: drive, advance one clock, compare.
    task automatic tick(input bit st, input bit ab, input bit hit);
        i_start         = st;
        i_abort         = ab;
        i_pattern_found = hit;
        cyc++;
        model_step(st, ab, hit);
        if (hit) last_hit_cyc = cyc;
        @(posedge i_clk);
        @(negedge i_clk);
        check_outs();
        if (o_timeout === 1'b1) begin
            n_to++;
            to_cyc = cyc;
        end
        if (o_lost === 1'b1) begin
            n_lost++;
            lost_cyc = cyc;
        end
    endtask

    task automatic zeros(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int mode, len, per;
        bit st, ab, h;

        i_reset         = 1'b1;
        i_start         = 1'b0;
        i_abort         = 1'b0;
        i_pattern_found = 1'b0;
        n_to = 0; n_lost = 0; to_cyc = 0; lost_cyc = 0; last_hit_cyc = 0;
        model_reset();
        repeat (3) @(negedge i_clk);
        check_reset_outs("reset");
        i_reset = 1'b0;

        // Start, flush length and lock on three hits
        tick(1'b1, 1'b0, 1'b0);
        lows = (o_det_resetn == 1'b0) ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (o_det_resetn == 1'b0) lows++;
        end
        chk("t1_flush_len", 32'(lows), 32'(FLUSH_CYC));
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        zeros(2);
        tick(1'b0, 1'b0, 1'b1);
        zeros(2);
        tick(1'b0, 1'b0, 1'b1);
        chk("t2_hits",   32'(o_hit_count), 32'(3));
        chk("t2_locked", 32'(o_locked),    32'(1));
        chk("t2_no_to",  32'(n_to),        32'(0));

        // Loss of lock after the hits stop, then auto re-arm
        zeros(24);
        chk("t4_lost_cnt", 32'(n_lost), 32'(1));
        chk("t4_gap",      32'(lost_cyc - last_hit_cyc), 32'(MAX_GAP));
        chk("t4_rearmed",  32'(o_det_resetn & o_busy & ~o_locked), 32'(1));
        tick(1'b0, 1'b1, 1'b0);

        // Window expiry with no hits
        n_to = 0;
        tick(1'b1, 1'b0, 1'b0);
        start_cyc = cyc;
        zeros(80);
        chk("t3_to_cnt", 32'(n_to),               32'(1));
        chk("t3_to_lat", 32'(to_cyc - start_cyc), 32'(FLUSH_CYC + PAT_LEN - 1 + WINDOW));
        chk("t3_busy",   32'(o_busy),             32'(0));
        chk("t3_hits",   32'(o_hit_count),        32'(0));

        // Abort together with start, then abort mid-track
        n_to = 0; n_lost = 0;
        tick(1'b1, 1'b1, 1'b0);
        chk("t5_abort_start", 32'(o_busy), 32'(0));
        tick(1'b1, 1'b0, 1'b0);
        zeros(7);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        zeros(4);
        chk("t5_locked", 32'(o_locked), 32'(1));
        tick(1'b0, 1'b1, 1'b0);
        chk("t5_abort_idle", 32'(o_busy | o_det_resetn), 32'(0));
        zeros(80);
        chk("t5_no_pulses", 32'(n_to + n_lost), 32'(0));

        // Saturating hit counter
        tick(1'b1, 1'b0, 1'b0);
        zeros(7);
        for (int k = 0; k < 300; k++) tick(1'b0, 1'b0, 1'b1);
        chk("sat_count", 32'(o_hit_count), 32'(HMAX));
        tick(1'b0, 1'b1, 1'b0);

        // Hit on the last window cycle completes lock; then async reset mid-track
        n_to = 0;
        tick(1'b1, 1'b0, 1'b0);
        zeros(9);
        tick(1'b0, 1'b0, 1'b1);
        zeros(9);
        tick(1'b0, 1'b0, 1'b1);
        zeros(50);
        tick(1'b0, 1'b0, 1'b1);
        chk("t6_locked", 32'(o_locked), 32'(1));
        zeros(5);
        chk("t6_no_to", 32'(n_to), 32'(0));
        #2 i_reset = 1'b1;
        #1 check_reset_outs("t6_async");
        model_reset();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;

        // Randomized traffic in blocks of differing hit density
        for (int b = 0; b < 40; b++) begin
            mode = int'($urandom_range(0, 4));
            len  = int'($urandom_range(60, 200));
            per  = int'($urandom_range(MAX_GAP - 2, MAX_GAP + 2));
            for (int k = 0; k < len; k++) begin
                st = ($urandom_range(0, 15) == 0);
                ab = ($urandom_range(0, 199) == 0);
                case (mode)
                    0:       h = 1'b0;
                    1:       h = ($urandom_range(0, 3) == 0);
                    2:       h = ($urandom_range(0, 29) == 0);
                    3:       h = (k % per == 0);
                    default: h = 1'b1;
                endcase
                tick(st, ab, h);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
